// File: rtl/uarc_arb_pkg.sv
// uarc_arb_pkg: shared state/command types and sizing helper for the UARC bus arbiter.
package uarc_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_STREAM} state_t;
  typedef enum logic [1:0] {CMD_KILL, CMD_INCEPT, CMD_SEND, CMD_STREAM} cmd_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uarc_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select; the first requester after ptr wins.
module rr_picker import uarc_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] c;
  // Scan from the farthest candidate down so the nearest one after ptr is kept.
  always_comb begin
    found = |req;
    idx = '0;
    c = '0;
    for (int i = N; i >= 1; i--) begin
      c = W'((int'(ptr) + i) % N);
      if (req[c]) idx = c;
    end
  end
endmodule

// File: rtl/uarc_bus_arbiter.sv
// uarc_bus_arbiter: round-robin share of one UARC receiver bus among REQUESTERS senders.
// Define UARC_ARB_TIMEOUT_EN to force-release grants that go TIMEOUT cycles without an ack.
module uarc_bus_arbiter import uarc_arb_pkg::*; #(
  parameter int WORD_MAG = 5,
  parameter int REQUESTERS = 4,
  parameter int TIMEOUT = 16,
  localparam int WORD_WIDTH = 1 << WORD_MAG,
  localparam int IW = idx_width(REQUESTERS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 bus_enable,
  input  logic [REQUESTERS-1:0]                req_kills,
  input  logic [REQUESTERS-1:0]                req_incepts,
  input  logic [REQUESTERS-1:0]                req_sends,
  input  logic [REQUESTERS-1:0]                req_streams,
  output logic [REQUESTERS-1:0]                req_kill_acks,
  output logic [REQUESTERS-1:0]                req_incept_acks,
  output logic [REQUESTERS-1:0]                req_send_acks,
  output logic [REQUESTERS-1:0]                req_stream_acks,
  input  logic [REQUESTERS-1:0][WORD_WIDTH-1:0] req_datas,
  input  logic [REQUESTERS-1:0][WORD_WIDTH-1:0] req_self_permissions,
  input  logic [REQUESTERS-1:0][WORD_WIDTH-1:0] req_self_addresses,
  input  logic [REQUESTERS-1:0][WORD_WIDTH-1:0] req_incept_permissions,
  input  logic [REQUESTERS-1:0][WORD_WIDTH-1:0] req_incept_addresses,
  output logic                                 out_kill,
  output logic                                 out_incept,
  output logic                                 out_send,
  output logic                                 out_stream,
  output logic [WORD_WIDTH-1:0]                out_data,
  output logic [WORD_WIDTH-1:0]                out_self_permission,
  output logic [WORD_WIDTH-1:0]                out_self_address,
  output logic [WORD_WIDTH-1:0]                out_incept_permission,
  output logic [WORD_WIDTH-1:0]                out_incept_address,
  input  logic                                 out_kill_ack,
  input  logic                                 out_incept_ack,
  input  logic                                 out_send_ack,
  input  logic                                 out_stream_ack,
  output logic                                 grant_valid,
  output logic [IW-1:0]                        grant_id,
  output logic                                 timeout_err
);
  state_t state, state_nx;
  cmd_t g_cmd;
  logic [IW-1:0] rr, pick;
  logic [REQUESTERS-1:0] any_req, g_oh;
  logic found, p_stream, cmd_live, kill_hit, incept_hit, send_hit, stream_hit, ack, tmo;
  assign any_req = req_kills | req_incepts | req_sends | req_streams;
  assign grant_valid = state != ST_IDLE;
  rr_picker #(.N(REQUESTERS), .W(IW)) u_pick (.req(any_req), .ptr(rr), .found(found), .idx(pick));
  always_comb begin
    g_cmd = req_kills[grant_id] ? CMD_KILL : req_incepts[grant_id] ? CMD_INCEPT :
            req_sends[grant_id] ? CMD_SEND : CMD_STREAM;
    g_oh = REQUESTERS'(1) << grant_id;
    p_stream = !req_kills[pick] && !req_incepts[pick] && !req_sends[pick];
    out_kill = state == ST_CMD && g_cmd == CMD_KILL;
    out_incept = state == ST_CMD && g_cmd == CMD_INCEPT;
    out_send = state == ST_CMD && g_cmd == CMD_SEND;
    out_stream = state == ST_STREAM && req_streams[grant_id];
    cmd_live = out_kill || out_incept || out_send;
    kill_hit = out_kill && out_kill_ack;
    incept_hit = out_incept && out_incept_ack;
    send_hit = out_send && out_send_ack;
    stream_hit = out_stream && out_stream_ack;
    ack = kill_hit || incept_hit || send_hit || stream_hit;
    req_kill_acks = kill_hit ? g_oh : '0;
    req_incept_acks = incept_hit ? g_oh : '0;
    req_send_acks = send_hit ? g_oh : '0;
    req_stream_acks = stream_hit ? g_oh : '0;
    out_data = grant_valid ? req_datas[grant_id] : '0;
    out_self_permission = grant_valid ? req_self_permissions[grant_id] : '0;
    out_self_address = grant_valid ? req_self_addresses[grant_id] : '0;
    out_incept_permission = grant_valid ? req_incept_permissions[grant_id] : '0;
    out_incept_address = grant_valid ? req_incept_addresses[grant_id] : '0;
    // A withdrawn request (no live command) releases the bus like an ack would.
    state_nx = state == ST_IDLE ? (bus_enable && found ? (p_stream ? ST_STREAM : ST_CMD) : ST_IDLE) :
               state == ST_CMD ? (ack || !cmd_live ? ST_IDLE : ST_CMD) :
               (out_stream ? ST_STREAM : ST_IDLE);
    if (tmo) state_nx = ST_IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      grant_id <= '0;
      rr <= IW'(REQUESTERS - 1);
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && state_nx != ST_IDLE) begin
        grant_id <= pick;
        rr <= pick;
      end
    end
  end
`ifdef UARC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  // rr already points at the offender, so after release it has lowest priority.
  assign tmo = state != ST_IDLE && !ack && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state == ST_IDLE || state_nx == ST_IDLE || ack) ? '0 : cnt + 1'b1;
      timeout_err <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uarc_bus_arbiter.sv
// tb_uarc_bus_arbiter: randomized scoreboard bench for uarc_bus_arbiter.
module tb_uarc_bus_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  typedef struct {int id; int cmd; logic [5*W-1:0] pl;} exp_t;
  logic clk = 0, reset = 0, bus_enable = 0;
  logic [N-1:0] rk = '0, ri = '0, rs = '0, rq = '0;
  logic [N-1:0] ka, ia, sa, qa;
  logic [N-1:0][W-1:0] d, sp, sad, ip, iad;
  logic [3:0] a_drv = '0;
  logic ok, oi, os, ost, gv, terr;
  logic [W-1:0] od, osp, osa, oip, oia;
  logic [1:0] gid;
  exp_t sb[$];
  int checks = 0, failures = 0, rr_m = N - 1, ack_mode = 1, cur_id = 0, cur_cmd = 0;
  int srem[N];
  logic rand_en = 0, in_tx = 0;

  always #5 clk = ~clk;

  uarc_bus_arbiter dut (
    .clk(clk), .reset(reset), .bus_enable(bus_enable),
    .req_kills(rk), .req_incepts(ri), .req_sends(rs), .req_streams(rq),
    .req_kill_acks(ka), .req_incept_acks(ia), .req_send_acks(sa), .req_stream_acks(qa),
    .req_datas(d), .req_self_permissions(sp), .req_self_addresses(sad),
    .req_incept_permissions(ip), .req_incept_addresses(iad),
    .out_kill(ok), .out_incept(oi), .out_send(os), .out_stream(ost),
    .out_data(od), .out_self_permission(osp), .out_self_address(osa),
    .out_incept_permission(oip), .out_incept_address(oia),
    .out_kill_ack(a_drv[0]), .out_incept_ack(a_drv[1]), .out_send_ack(a_drv[2]),
    .out_stream_ack(a_drv[3]),
    .grant_valid(gv), .grant_id(gid), .timeout_err(terr)
  );

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic live(input int j, input int c);
    return c == 0 ? rk[j] : c == 1 ? ri[j] : c == 2 ? rs[j] : rq[j];
  endfunction

  // Monitor: pops one expected grant per transaction and checks bus + ack routing.
  initial forever begin
    logic [4*N-1:0] exp_ack;
    exp_t e;
    @(negedge clk);
    if (gv && !in_tx) begin
      if (sb.size() == 0) chk("pending_items", sb.size(), 1);
      else begin
        e = sb.pop_front();
        cur_id = e.id;
        cur_cmd = e.cmd;
        in_tx = 1;
        chk("grant_id", gid, e.id);
        chk("payload", {od, osp, osa, oip, oia}, e.pl);
      end
    end else if (!gv) in_tx = 0;
    if (in_tx) chk("out_cmd", {gid, ost, os, oi, ok},
                   {2'(cur_id), live(cur_id, cur_cmd) ? 4'(1 << cur_cmd) : 4'b0});
    else chk("idle_outputs", {gv, ost, os, oi, ok, od, osp, osa, oip, oia}, '0);
`ifndef UARC_ARB_TIMEOUT_EN
    chk("timeout_err", terr, 0);
`endif
    #3;
    exp_ack = '0;
    if (in_tx && live(cur_id, cur_cmd) && a_drv[cur_cmd]) exp_ack[cur_cmd * N + cur_id] = 1'b1;
    chk("ack_route", {qa, sa, ia, ka}, exp_ack);
  end

  // One bus cycle: receiver acks (junk on other lines), senders drop on their ack.
  task automatic cycle();
    logic [3:0] a;
    logic [N-1:0] kc, ic, sc, qc;
    @(negedge clk);
    #1;
    if (rand_en) bus_enable = ($urandom_range(4) != 0);
    a = 4'($urandom) & 4'($urandom);
    if (in_tx) a[cur_cmd] = ack_mode == 2 || (ack_mode == 1 && $urandom_range(1) == 1);
    a_drv = a;
    #1;
    kc = ka; ic = ia; sc = sa; qc = qa;
    @(posedge clk);
    #1;
    rk &= ~kc; ri &= ~ic; rs &= ~sc;
    for (int i = 0; i < N; i++)
      if (qc[i]) begin
        srem[i]--;
        if (srem[i] <= 0) rq[i] = 1'b0;
      end
    a_drv = '0;
  endtask

  task automatic rand_payload();
    for (int x = 0; x < N; x++) begin
      d[x] = $urandom; sp[x] = $urandom; sad[x] = $urandom; ip[x] = $urandom; iad[x] = $urandom;
    end
  endtask

  // Reference order: serve the first pending sender after the last one granted,
  // one command per grant in kill > incept > send > stream order.
  task automatic issue(input logic [N-1:0] k, i, s, q, input int slen);
    logic [N-1:0] pk, pi, ps, pq;
    int j, c;
    pk = k; pi = i; ps = s; pq = q; j = 0;
    for (int x = 0; x < N; x++) srem[x] = slen > 0 ? slen : 1 + $urandom_range(3);
    while (|(pk | pi | ps | pq)) begin
      for (int o = 1; o <= N; o++) begin
        j = (rr_m + o) % N;
        if (pk[j] | pi[j] | ps[j] | pq[j]) break;
      end
      c = pk[j] ? 0 : pi[j] ? 1 : ps[j] ? 2 : 3;
      if (c == 0) pk[j] = 0; else if (c == 1) pi[j] = 0; else if (c == 2) ps[j] = 0; else pq[j] = 0;
      sb.push_back('{j, c, {d[j], sp[j], sad[j], ip[j], iad[j]}});
      rr_m = j;
    end
    rk = k; ri = i; rs = s; rq = q;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((|(rk | ri | rs | rq) || gv) && n < 400);
    chk("round_done", n < 400, 1);
  endtask

  task automatic run_round(input logic [N-1:0] k, i, s, q, input int slen);
    rand_payload();
    issue(k, i, s, q, slen);
    drain();
  endtask

  initial begin
    int gexp;
    logic [N-1:0] act;
    rand_payload();
    #12;
    chk("reset_state", {gv, gid, ok, oi, os, ost, terr, ka, ia, sa, qa}, '0);
    @(posedge clk);
    #1;
    reset = 1;
    bus_enable = 1;
    // Sender 0 send: out at t+1, ack at t+3, idle at t+4.
    d[0] = 32'h0000_1234;
    ack_mode = 0;
    issue(4'b0000, 4'b0000, 4'b0001, 4'b0000, 0);
    cycle();
    chk("t1_latency", {gv, gid, os}, {1'b1, 2'd0, 1'b1});
    chk("t1_data", od, 32'h0000_1234);
    cycle();
    cycle();
    ack_mode = 2;
    cycle();
    chk("t1_release", {gv, rs}, '0);
    ack_mode = 1;
    run_round(4'b0000, 4'b0000, 4'b0110, 4'b0000, 0);
    run_round(4'b0000, 4'b0000, 4'b0001, 4'b1000, 3);
    run_round(4'b0100, 4'b0000, 4'b0100, 4'b0000, 0);
    rand_en = 1;
    for (int r = 0; r < 30; r++) begin
      act = 4'($urandom);
      run_round(act & 4'($urandom), act & 4'($urandom), act & 4'($urandom), act & 4'($urandom), 0);
    end
    // Bus disabled blocks new grants.
    rand_en = 0;
    bus_enable = 0;
    rand_payload();
    ack_mode = 0;
    issue(4'b0000, 4'b0000, 4'b0010, 4'b0000, 0);
    repeat (5) begin
      cycle();
      chk("t5_blocked", gv, 0);
    end
    bus_enable = 1;
    cycle();
    chk("t5_grant", {gv, gid}, {1'b1, 2'd1});
    ack_mode = 1;
    drain();
    // Unacked send holds the bus; reset then clears it mid-transaction.
    rand_payload();
    ack_mode = 0;
    issue(4'b0000, 4'b0000, 4'b1100, 4'b0000, 0);
    gexp = sb[0].id;
`ifndef UARC_ARB_TIMEOUT_EN
    repeat (20) cycle();
    chk("t6_hold", {gv, gid, os}, {1'b1, 2'(gexp), 1'b1});
`else
    repeat (3) cycle();
`endif
    #2;
    reset = 0;
    #1;
    chk("mid_reset", {gv, gid, ok, oi, os, ost, od}, '0);
    rk = '0; ri = '0; rs = '0; rq = '0;
    sb.delete();
    rr_m = N - 1;
    repeat (2) cycle();
    @(posedge clk);
    #1;
    reset = 1;
    ack_mode = 1;
    run_round(4'b0000, 4'b0000, 4'b1111, 4'b0000, 0);
    rand_en = 1;
    for (int r = 0; r < 5; r++) begin
      act = 4'($urandom);
      run_round(act & 4'($urandom), act & 4'($urandom), act & 4'($urandom), act & 4'($urandom), 0);
    end
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
